// File: rtl/sgmii_an_pkg.sv
// Shared types and constants for the SGMII auto-negotiation state machine:
// state encoding, config-word bit positions and the status word layout.
package sgmii_an_pkg;

   typedef enum logic [2:0] {
      AN_ENABLE      = 3'd0,
      AN_RESTART     = 3'd1,
      ABILITY_DETECT = 3'd2,
      ACK_DETECT     = 3'd3,
      COMPLETE_ACK   = 3'd4,
      IDLE_DETECT    = 3'd5,
      LINK_OK        = 3'd6
   } an_state_e;

   typedef enum logic [1:0] {
      SPEED_10M   = 2'b00,
      SPEED_100M  = 2'b01,
      SPEED_1000M = 2'b10
   } an_speed_e;

   localparam int CONFIG_ACK_BIT     = 14;
   localparam int PARTNER_LINK_BIT   = 15;
   localparam int PARTNER_DUPLEX_BIT = 12;
   localparam int PARTNER_SPEED_LSB  = 10;

   localparam logic [15:0] ACK_MASK     = 16'h0001 << CONFIG_ACK_BIT;
   localparam logic [15:0] ABILITY_MASK = ~ACK_MASK;

   function automatic logic [15:0] pack_status(input logic       link,
                                               input logic       duplex,
                                               input an_speed_e  speed,
                                               input logic       complete,
                                               input an_state_e  state);
      logic [15:0] s;
      s                              = '0;
      s[PARTNER_LINK_BIT]            = link;
      s[PARTNER_DUPLEX_BIT]          = duplex;
      s[PARTNER_SPEED_LSB +: 2]      = speed;
      s[3]                           = complete;
      s[2:0]                         = state;
      return s;
   endfunction

endpackage

// File: rtl/sgmii_an_match_cnt.sv
// Saturating 0..3 counter of consecutive strobes whose masked word repeats
// and carries the REQUIRED bits; used for ability, ack and idle detection.
module sgmii_an_match_cnt
   import sgmii_an_pkg::*;
#(
   parameter logic [15:0] MASK     = ABILITY_MASK,
   parameter logic [15:0] REQUIRED = 16'h0000
) (
   input  logic        clock_i,
   input  logic        reset_ni,
   input  logic        clear_i,
   input  logic        strobe_i,
   input  logic        kill_i,
   input  logic [15:0] word_i,
   output logic        match_o
);

   logic [1:0]  cnt_q, cnt_d;
   logic [15:0] word_q, word_d;

   always_comb begin
      cnt_d  = cnt_q;
      word_d = word_q;
      if (clear_i) begin
         cnt_d  = 2'd0;
         word_d = '0;
      end else if (strobe_i) begin
         word_d = word_i;
         if ((word_i & REQUIRED) != REQUIRED)
            cnt_d = 2'd0;
         else if ((word_i & MASK) == (word_q & MASK))
            cnt_d = (cnt_q == 2'd3) ? 2'd3 : cnt_q + 2'd1;
         else
            cnt_d = 2'd1;
      end else if (kill_i) begin
         cnt_d = 2'd0;
      end
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         cnt_q  <= 2'd0;
         word_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         word_q <= word_d;
      end
   end

   assign match_o = (cnt_q == 2'd3);

endmodule

// File: rtl/sgmii_an_fsm.sv
// SGMII (clause-37 style) auto-negotiation: exchanges config words with the
// partner, latches its link/duplex/speed and reports LINK_OK.
module sgmii_an_fsm
   import sgmii_an_pkg::*;
#(
   parameter int          LINK_TIMER    = 200000,
   parameter logic [15:0] LOCAL_ABILITY = 16'h0001
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        rx_sync,
   input  logic        rx_config_valid,
   input  logic [15:0] rx_config_reg,
   input  logic        rx_idle,
   input  logic        an_restart_config,
   output logic        tx_config_en,
   output logic [15:0] tx_config_reg,
   output logic        an_complete,
   output logic [15:0] eth_status
);

   localparam int                 TIMER_W    = $clog2(LINK_TIMER);
   localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(LINK_TIMER - 1);
   localparam logic [15:0]        LOCAL_WORD = LOCAL_ABILITY & ABILITY_MASK;
   localparam logic [15:0]        LOCAL_ACK  = LOCAL_WORD | ACK_MASK;

   an_state_e          state_q, state_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic               restart_prev_q;
   logic [15:0]        rx_word_q, rx_word_d;
   logic               partner_link_q, partner_link_d;
   logic               partner_duplex_q, partner_duplex_d;
   an_speed_e          partner_speed_q, partner_speed_d;
   logic               tx_config_en_q, tx_config_en_d;
   logic [15:0]        tx_config_reg_q, tx_config_reg_d;
   logic               an_complete_q, an_complete_d;
   logic [15:0]        eth_status_q, eth_status_d;

   logic counters_clear, idle_strobe;
   logic ability_match, ack_match, idle_match;
   logic timer_done, restart_edge, word_zero;

   assign counters_clear = (state_q == AN_ENABLE);
   // A config word wins over an idle strobe arriving in the same cycle.
   assign idle_strobe    = rx_idle & ~rx_config_valid;
   assign timer_done     = (timer_q == '0);
   assign restart_edge   = an_restart_config & ~restart_prev_q;
   assign word_zero      = ((rx_word_q & ABILITY_MASK) == 16'h0000);

   sgmii_an_match_cnt #(.MASK(ABILITY_MASK), .REQUIRED(16'h0000)) u_ability_cnt (
      .clock_i (clock), .reset_ni (reset_n), .clear_i (counters_clear),
      .strobe_i(rx_config_valid), .kill_i (idle_strobe), .word_i (rx_config_reg),
      .match_o (ability_match));

   sgmii_an_match_cnt #(.MASK(ABILITY_MASK), .REQUIRED(ACK_MASK)) u_ack_cnt (
      .clock_i (clock), .reset_ni (reset_n), .clear_i (counters_clear),
      .strobe_i(rx_config_valid), .kill_i (idle_strobe), .word_i (rx_config_reg),
      .match_o (ack_match));

   sgmii_an_match_cnt #(.MASK(16'h0000), .REQUIRED(16'h0000)) u_idle_cnt (
      .clock_i (clock), .reset_ni (reset_n), .clear_i (counters_clear),
      .strobe_i(idle_strobe), .kill_i (rx_config_valid), .word_i (16'h0000),
      .match_o (idle_match));

   always_comb begin
      state_d = state_q;
      case (state_q)
         AN_ENABLE:      state_d = AN_RESTART;
         AN_RESTART:     if (timer_done) state_d = ABILITY_DETECT;
         ABILITY_DETECT: if (ability_match && !word_zero) state_d = ACK_DETECT;
         ACK_DETECT: begin
            if (ack_match)                       state_d = COMPLETE_ACK;
            else if (ability_match && word_zero) state_d = AN_ENABLE;
         end
         COMPLETE_ACK: begin
            if (ability_match && word_zero) state_d = AN_ENABLE;
            else if (timer_done)            state_d = IDLE_DETECT;
         end
         IDLE_DETECT:    if (timer_done && idle_match) state_d = LINK_OK;
         LINK_OK:        if (ability_match) state_d = AN_ENABLE;
         default:        state_d = AN_ENABLE;
      endcase
      if (!rx_sync || restart_edge)
         state_d = AN_ENABLE;

      timer_d = (timer_q != '0) ? timer_q - TIMER_W'(1) : timer_q;
      if ((state_d != state_q) && (state_d inside {AN_RESTART, COMPLETE_ACK, IDLE_DETECT}))
         timer_d = TIMER_LOAD;

      rx_word_d = rx_word_q;
      if (state_q == AN_ENABLE)
         rx_word_d = '0;
      else if (rx_config_valid)
         rx_word_d = rx_config_reg;

      // rx_word_q is the word that produced the current ack_match.
      partner_link_d   = partner_link_q;
      partner_duplex_d = partner_duplex_q;
      partner_speed_d  = partner_speed_q;
      if ((state_d == COMPLETE_ACK) && (state_q != COMPLETE_ACK)) begin
         partner_link_d   = rx_word_q[PARTNER_LINK_BIT];
         partner_duplex_d = rx_word_q[PARTNER_DUPLEX_BIT];
         partner_speed_d  = an_speed_e'(rx_word_q[PARTNER_SPEED_LSB +: 2]);
      end

      case (state_d)
         AN_ENABLE, AN_RESTART: tx_config_reg_d = 16'h0000;
         ABILITY_DETECT:        tx_config_reg_d = LOCAL_WORD;
         default:               tx_config_reg_d = LOCAL_ACK;
      endcase
      tx_config_en_d = !(state_d inside {IDLE_DETECT, LINK_OK});
      an_complete_d  = (state_d == LINK_OK);
      eth_status_d   = pack_status(partner_link_d, partner_duplex_d, partner_speed_d,
                                   an_complete_d, state_d);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q          <= AN_ENABLE;
         timer_q          <= '0;
         restart_prev_q   <= 1'b0;
         rx_word_q        <= '0;
         partner_link_q   <= 1'b0;
         partner_duplex_q <= 1'b0;
         partner_speed_q  <= SPEED_10M;
         tx_config_en_q   <= 1'b1;
         tx_config_reg_q  <= '0;
         an_complete_q    <= 1'b0;
         eth_status_q     <= '0;
      end else begin
         state_q          <= state_d;
         timer_q          <= timer_d;
         restart_prev_q   <= an_restart_config;
         rx_word_q        <= rx_word_d;
         partner_link_q   <= partner_link_d;
         partner_duplex_q <= partner_duplex_d;
         partner_speed_q  <= partner_speed_d;
         tx_config_en_q   <= tx_config_en_d;
         tx_config_reg_q  <= tx_config_reg_d;
         an_complete_q    <= an_complete_d;
         eth_status_q     <= eth_status_d;
      end
   end

   assign tx_config_en  = tx_config_en_q;
   assign tx_config_reg = tx_config_reg_q;
   assign an_complete   = an_complete_q;
   assign eth_status    = eth_status_q;

endmodule

// File: tb/tb_sgmii_an_fsm.sv
// Bench for sgmii_an_fsm: directed negotiation scenarios followed by a random
// partner, all cross-checked every cycle against a history-based model.
module tb_sgmii_an_fsm;

   localparam int          LT = 16;
   localparam logic [15:0] LA = 16'h0001;
   localparam int S_ENABLE = 0, S_RESTART = 1, S_ABILITY = 2, S_ACK = 3,
                  S_COMPLETE = 4, S_IDLE = 5, S_LINK_OK = 6;

   logic        clock = 1'b0;
   logic        reset_n, rx_sync, rx_config_valid, rx_idle, an_restart_config;
   logic [15:0] rx_config_reg;
   logic        tx_config_en, an_complete;
   logic [15:0] tx_config_reg, eth_status;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: a rolling history of config words instead of counters.
   int          m_state, m_cis, m_idles;
   logic [15:0] m_hist[$];
   bit          m_prev_rs, m_link, m_dup;
   bit [1:0]    m_speed;

   logic [15:0] wtab [6] = '{16'h0001, 16'h9801, 16'hD801, 16'h4001, 16'h0000, 16'h0021};
   int          mode;
   logic [15:0] rw;

   sgmii_an_fsm #(.LINK_TIMER(LT), .LOCAL_ABILITY(LA)) dut (
      .clock(clock), .reset_n(reset_n), .rx_sync(rx_sync),
      .rx_config_valid(rx_config_valid), .rx_config_reg(rx_config_reg),
      .rx_idle(rx_idle), .an_restart_config(an_restart_config),
      .tx_config_en(tx_config_en), .tx_config_reg(tx_config_reg),
      .an_complete(an_complete), .eth_status(eth_status));

   always #4 clock = ~clock;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [15:0] exp_tx_reg(input int s);
      if (s <= S_RESTART) return 16'h0000;
      if (s == S_ABILITY) return LA;
      return LA | 16'h4000;
   endfunction

   function automatic bit exp_en(input int s);
      return !(s == S_IDLE || s == S_LINK_OK);
   endfunction

   function automatic logic [15:0] m_eth();
      logic [15:0] e;
      e = '0;
      e[15] = m_link;
      e[12] = m_dup;
      e[11:10] = m_speed;
      e[3] = (m_state == S_LINK_OK);
      e[2:0] = 3'(m_state);
      return e;
   endfunction

   function automatic bit three_equal(input logic [15:0] mask);
      int n;
      n = m_hist.size();
      if (n < 3) return 1'b0;
      return ((m_hist[n-1] & mask) == (m_hist[n-2] & mask)) &&
             ((m_hist[n-2] & mask) == (m_hist[n-3] & mask));
   endfunction

   task automatic model_reset();
      m_state = S_ENABLE; m_cis = 0; m_idles = 0; m_hist.delete();
      m_prev_rs = 1'b0; m_link = 1'b0; m_dup = 1'b0; m_speed = 2'b00;
   endtask

   task automatic model_tick();
      bit ab, ack, idl, done, zero, edge_rs;
      int nxt;
      logic [15:0] last;
      last    = (m_hist.size() > 0) ? m_hist[m_hist.size()-1] : 16'h0000;
      ab      = three_equal(16'hBFFF);
      ack     = three_equal(16'hFFFF) && last[14];
      zero    = ((last & 16'hBFFF) == 16'h0000);
      idl     = (m_idles >= 3);
      done    = (m_cis >= LT - 1);
      edge_rs = an_restart_config && !m_prev_rs;
      nxt = m_state;
      case (m_state)
         S_ENABLE:   nxt = S_RESTART;
         S_RESTART:  if (done) nxt = S_ABILITY;
         S_ABILITY:  if (ab && !zero) nxt = S_ACK;
         S_ACK:      if (ack) nxt = S_COMPLETE; else if (ab && zero) nxt = S_ENABLE;
         S_COMPLETE: if (ab && zero) nxt = S_ENABLE; else if (done) nxt = S_IDLE;
         S_IDLE:     if (done && idl) nxt = S_LINK_OK;
         S_LINK_OK:  if (ab) nxt = S_ENABLE;
         default:    nxt = S_ENABLE;
      endcase
      if (!rx_sync || edge_rs) nxt = S_ENABLE;
      if (nxt == S_COMPLETE && m_state != S_COMPLETE) begin
         m_link = last[15]; m_dup = last[12]; m_speed = last[11:10];
      end
      if (m_state == S_ENABLE) begin
         m_hist.delete(); m_idles = 0;
      end else if (rx_config_valid) begin
         m_hist.push_back(rx_config_reg);
         if (m_hist.size() > 3) void'(m_hist.pop_front());
         m_idles = 0;
      end else if (rx_idle) begin
         m_hist.delete();
         if (m_idles < 100) m_idles++;
      end
      m_cis = (nxt == m_state) ? ((m_cis < 100000) ? m_cis + 1 : m_cis) : 0;
      m_prev_rs = an_restart_config;
      m_state = nxt;
   endtask

   task automatic step();
      @(posedge clock);
      model_tick();
      #1;
      chk("eth_status", eth_status, m_eth());
      chk("tx_config_en", {15'b0, tx_config_en}, {15'b0, exp_en(m_state)});
      chk("an_complete", {15'b0, an_complete}, {15'b0, m_state == S_LINK_OK});
      if (m_state <= S_COMPLETE)
         chk("tx_config_reg", tx_config_reg, exp_tx_reg(m_state));
   endtask

   task automatic send_word(input logic [15:0] w, input int gap);
      rx_config_valid = 1'b1; rx_config_reg = w;
      step();
      rx_config_valid = 1'b0;
      repeat (gap - 1) step();
   endtask

   task automatic send_idle(input int gap);
      rx_idle = 1'b1;
      step();
      rx_idle = 1'b0;
      repeat (gap - 1) step();
   endtask

   task automatic idle_until(input int target, input int max_slots);
      for (int n = 0; n < max_slots && m_state != target; n++) send_idle(4);
   endtask

   task automatic loopback_until(input int target, input int max_slots);
      for (int n = 0; n < max_slots && m_state != target; n++) begin
         if (exp_en(m_state)) send_word(exp_tx_reg(m_state), 4);
         else send_idle(4);
      end
   endtask

   task automatic wait_state(input int target, input int max_cycles);
      for (int n = 0; n < max_cycles && m_state != target; n++) step();
   endtask

   task automatic chk_state(input string tag, input int target);
      chk(tag, {13'b0, eth_status[2:0]}, 16'(target));
   endtask

   initial begin
      reset_n = 1'b0; rx_sync = 1'b1; rx_config_valid = 1'b0; rx_idle = 1'b0;
      an_restart_config = 1'b0; rx_config_reg = '0;
      model_reset();
      repeat (3) @(posedge clock);
      #1;
      chk("reset_tx_en", {15'b0, tx_config_en}, 16'h0001);
      chk("reset_tx_reg", tx_config_reg, 16'h0000);
      chk("reset_an_complete", {15'b0, an_complete}, 16'h0000);
      chk("reset_eth_status", eth_status, 16'h0000);
      #2 reset_n = 1'b1;

      // Loopback: our own transmit words come back as the partner's.
      loopback_until(S_LINK_OK, 60);
      chk("loopback_eth_status", eth_status, 16'h000E);
      chk("loopback_tx_en", {15'b0, tx_config_en}, 16'h0000);

      // One-cycle sync loss in LINK_OK.
      rx_sync = 1'b0;
      step();
      rx_sync = 1'b1;
      chk_state("syncloss_state", S_ENABLE);
      chk("syncloss_an_complete", {15'b0, an_complete}, 16'h0000);
      chk("syncloss_tx_en", {15'b0, tx_config_en}, 16'h0001);

      // Partner advertising 1000M full duplex with link up.
      idle_until(S_ABILITY, 10);
      repeat (3) send_word(16'h9801, 4);
      repeat (3) send_word(16'hD801, 4);
      idle_until(S_LINK_OK, 40);
      chk("partner_eth_status", eth_status, 16'h980E);

      // Restart edge, then all-zero words during ACK_DETECT.
      an_restart_config = 1'b1;
      step();
      chk_state("restart_edge_state", S_ENABLE);
      idle_until(S_ABILITY, 10);
      chk_state("restart_level_once", S_ABILITY);
      repeat (3) send_word(16'h0001, 1);
      wait_state(S_ACK, 4);
      chk_state("zero_pre_ack", S_ACK);
      repeat (3) send_word(16'h0000, 1);
      wait_state(S_ENABLE, 4);
      chk_state("zero_to_enable", S_ENABLE);
      an_restart_config = 1'b0;
      step();
      chk_state("zero_then_restart", S_RESTART);

      // Alternating words never produce an ability match.
      idle_until(S_ABILITY, 10);
      for (int i = 0; i < 50; i++) begin
         send_word(16'h0001, 2);
         send_word(16'h0021, 2);
      end
      chk_state("mismatch_state", S_ABILITY);
      chk("mismatch_tx_reg", tx_config_reg, 16'h0001);

      // Asynchronous reset pulse in COMPLETE_ACK.
      repeat (3) send_word(16'h0001, 1);
      wait_state(S_ACK, 4);
      repeat (3) send_word(16'h4001, 1);
      wait_state(S_COMPLETE, 4);
      chk_state("midreset_pre_state", S_COMPLETE);
      #1 reset_n = 1'b0;
      #2;
      chk("midreset_tx_en", {15'b0, tx_config_en}, 16'h0001);
      chk("midreset_tx_reg", tx_config_reg, 16'h0000);
      chk("midreset_an_complete", {15'b0, an_complete}, 16'h0000);
      chk("midreset_eth_status", eth_status, 16'h0000);
      #1 reset_n = 1'b1;
      model_reset();

      // Random partner behaviour.
      mode = 0; rw = 16'h0001;
      for (int c = 0; c < 4000; c++) begin
         int p;
         p = c % 256;
         if (p == 0) begin
            mode = int'($urandom_range(0, 3));
            rw   = wtab[$urandom_range(0, 5)];
         end
         rx_config_valid = 1'b0;
         rx_idle = 1'b0;
         case (mode)
            0: if (p % 4 == 0) begin
                  if (exp_en(m_state)) begin
                     rx_config_valid = 1'b1; rx_config_reg = exp_tx_reg(m_state);
                  end else rx_idle = 1'b1;
               end
            1: if (p % 4 == 0) begin
                  if (p < 192) begin
                     rx_config_valid = 1'b1;
                     rx_config_reg = (p < 96) ? rw : (rw | 16'h4000);
                  end else rx_idle = 1'b1;
               end
            2: if ($urandom_range(0, 2) == 0) begin
                  rx_config_valid = 1'b1; rx_config_reg = wtab[$urandom_range(0, 5)];
               end else if ($urandom_range(0, 3) == 0) rx_idle = 1'b1;
            default: if (p % 4 == 0) rx_idle = 1'b1;
         endcase
         if (rx_config_valid && $urandom_range(0, 7) == 0) rx_idle = 1'b1;
         rx_sync = ($urandom_range(0, 299) != 0);
         if ($urandom_range(0, 399) == 0) an_restart_config = !an_restart_config;
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
